order_content_tdp_ram: RTL

- Parametrised successor to the fixed 4096x200 order-content store in router_output_port_lookup.
- Port A is read/write with per-lane write mask and write-first output; port B is read-only.
- Has a self-clearing init sweep after reset and read-valid flags.
- Sits between the order parser (port A) and the order-match lookup (port B).

---
 rtl/order_content_pkg.sv | 23 ++
 rtl/order_content_init_fsm.sv | 66 ++++++
 rtl/order_content_tdp_ram.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/order_content_pkg.sv
// Shared types and helpers for the order-content true-dual-port store.
// State encoding, ceil-log2 and lane-width helpers used by the top and the init FSM.
package order_content_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int lane_width(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

endpackage

// File: rtl/order_content_init_fsm.sv
// Post-reset clear sweep: owns INIT/RUN state, the sweep address and init_done.
// While sweeping it takes over the array write port; in RUN it passes port A writes through.
module order_content_init_fsm
    import order_content_pkg::*;
#(
    parameter int DATA_WIDTH = 200,
    parameter int DEPTH      = 4096,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_din,
    output logic [LANES-1:0]      ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic [ADDR_WIDTH-1:0] init_addr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state     <= state_next;
            init_addr <= init_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        init_addr_next = init_addr;
        ram_we         = req_we;
        ram_addr       = req_addr;
        ram_din        = req_din;
        init_done      = 1'b0;
        case (state)
            ST_INIT: begin
                ram_we         = '1;
                ram_addr       = init_addr;
                ram_din        = '0;
                init_addr_next = init_addr + ADDR_WIDTH'(1);
                if (init_addr == LAST_ADDR) begin
                    state_next     = ST_RUN;
                    init_addr_next = '0;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: rtl/order_content_tdp_ram.sv
// Order-content store: port A read/write with lane mask and write-first data, port B read-only.
// Define ORDER_CONTENT_OUT_REG_EN to add an output register stage on both ports (latency 2).
module order_content_tdp_ram
    import order_content_pkg::*;
#(
    parameter int DATA_WIDTH = 200,
    parameter int DEPTH      = 4096,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic [LANES-1:0]      a_we,
    input  logic                  a_re,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_dout_vld,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_re,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_dout_vld
);

    localparam int                  LW      = lane_width(DATA_WIDTH, LANES);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_in_range;
    logic                  b_in_range;
    logic                  a_access;
    logic                  b_access;
    logic                  collide;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic [ADDR_WIDTH-1:0] b_idx;
    logic [LANES-1:0]      ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;

    logic [DATA_WIDTH-1:0] a_raw_q;
    logic [DATA_WIDTH-1:0] b_raw_q;
    logic [LANES-1:0]      a_mask_q;
    logic [LANES-1:0]      b_mask_q;
    logic [DATA_WIDTH-1:0] a_dat_q;
    logic [DATA_WIDTH-1:0] b_dat_q;
    logic                  a_vld_q;
    logic                  b_vld_q;
    logic [DATA_WIDTH-1:0] a_word;
    logic [DATA_WIDTH-1:0] b_word;

    assign a_in_range = {1'b0, a_addr} < DEPTH_W;
    assign b_in_range = {1'b0, b_addr} < DEPTH_W;
    assign a_access   = init_done & (a_re | (|a_we));
    assign b_access   = init_done & b_re;
    assign collide    = init_done & a_in_range & (|a_we) & (a_addr == b_addr);
    assign a_idx      = a_in_range ? a_addr : '0;
    assign b_idx      = b_in_range ? b_addr : '0;

    order_content_init_fsm #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .LANES     (LANES),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_init_fsm (
        .clk      (clk),
        .reset    (reset),
        .req_we   (a_in_range ? a_we : '0),
        .req_addr (a_addr),
        .req_din  (a_din),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .init_done(init_done)
    );

    // Plain array with registered read-old ports so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (ram_we[i]) begin
                mem[ram_addr][i*LW +: LW] <= ram_din[i*LW +: LW];
            end
        end
        if (a_access) begin
            a_raw_q <= mem[a_idx];
        end
        if (b_access) begin
            b_raw_q <= mem[b_idx];
        end
    end

    // Lanes flagged in a mask are taken from the captured write data instead of the
    // array read. Reset selects all lanes from zero data so the outputs start at zero;
    // out-of-range accesses use the same trick to return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_mask_q <= '1;
            a_dat_q  <= '0;
            a_vld_q  <= 1'b0;
            b_mask_q <= '1;
            b_dat_q  <= '0;
            b_vld_q  <= 1'b0;
        end else begin
            a_vld_q <= a_access;
            b_vld_q <= b_access;
            if (a_access) begin
                a_mask_q <= a_in_range ? a_we : '1;
                a_dat_q  <= a_in_range ? a_din : '0;
            end
            if (b_access) begin
                b_mask_q <= !b_in_range ? '1 : (collide ? a_we : '0);
                b_dat_q  <= b_in_range ? a_din : '0;
            end
        end
    end

    always_comb begin
        a_word = a_raw_q;
        b_word = b_raw_q;
        for (int i = 0; i < LANES; i++) begin
            if (a_mask_q[i]) begin
                a_word[i*LW +: LW] = a_dat_q[i*LW +: LW];
            end
            if (b_mask_q[i]) begin
                b_word[i*LW +: LW] = b_dat_q[i*LW +: LW];
            end
        end
    end

`ifdef ORDER_CONTENT_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout     <= '0;
            a_dout_vld <= 1'b0;
            b_dout     <= '0;
            b_dout_vld <= 1'b0;
        end else begin
            a_dout     <= a_word;
            a_dout_vld <= a_vld_q;
            b_dout     <= b_word;
            b_dout_vld <= b_vld_q;
        end
    end
`else
    assign a_dout     = a_word;
    assign a_dout_vld = a_vld_q;
    assign b_dout     = b_word;
    assign b_dout_vld = b_vld_q;
`endif

endmodule
